// File: rtl/irq_controller.sv
// Multi-source interrupt controller: synchronises raw requests, latches pending/overrun per source,
// and presents the lowest-index enabled pending source as a vector held until a single-shot claim.
module irq_controller #(
  parameter int                 NUM_SRC     = 8,
  parameter int                 VEC_W       = 4,
  parameter logic [NUM_SRC-1:0] EDGE_MASK   = {NUM_SRC{1'b1}},
  parameter int                 SYNC_STAGES = 2
) (
  input  logic               CLOCK_50,
  input  logic               KEY0,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] irq_enable,
  input  logic               interrupt_ack,
  output logic [VEC_W-1:0]   interrupt_vector,
  output logic               irq_active,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] overrun
);

  if ((2 ** VEC_W) <= NUM_SRC) begin : g_bad_vec_w
    $error("irq_controller: VEC_W too small, need 2**VEC_W > NUM_SRC");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("irq_controller: SYNC_STAGES must be at least 2");
  end

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] s;
  logic [NUM_SRC-1:0] s_d;
  logic [NUM_SRC-1:0] claimed;
  logic [NUM_SRC-1:0] set_src;
  logic [NUM_SRC-1:0] claim_src;
  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] pending_nxt;
  logic [NUM_SRC-1:0] overrun_nxt;
  logic [NUM_SRC-1:0] claimed_nxt;
  logic [VEC_W-1:0]   win_vec;
  logic               ack_d;
  logic               ack_rise;
  logic               claim;

  assign s        = sync_q[SYNC_STAGES-1];
  assign ack_rise = interrupt_ack & ~ack_d;
  assign claim    = ack_rise & (interrupt_vector != '0);

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      s_d <= '0;
    end else begin
      sync_q[0] <= irq_src;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      s_d <= s;
    end
  end

  always_comb begin
    claim_src   = '0;
    set_src     = '0;
    win_vec     = '0;
    cand        = pending & irq_enable;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_src[i] = claim && (interrupt_vector == VEC_W'(i + 1));
      // A level source being claimed this cycle must not re-pend from the same high level.
      if (EDGE_MASK[i]) set_src[i] = s[i] & ~s_d[i];
      else              set_src[i] = s[i] & ~claimed[i] & ~claim_src[i];
    end
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) win_vec = VEC_W'(i + 1);
    end
    // A fresh edge coinciding with its own claim keeps pending but drops the overrun.
    pending_nxt = (pending & ~claim_src) | set_src;
    overrun_nxt = (overrun | (set_src & pending & EDGE_MASK)) & ~claim_src;
    claimed_nxt = (claimed | (claim_src & ~EDGE_MASK)) & s;
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      pending          <= '0;
      overrun          <= '0;
      claimed          <= '0;
      ack_d            <= 1'b0;
      interrupt_vector <= '0;
      irq_active       <= 1'b0;
    end else begin
      pending    <= pending_nxt;
      overrun    <= overrun_nxt;
      claimed    <= claimed_nxt;
      ack_d      <= interrupt_ack;
      irq_active <= |cand;
      // Zero means idle and free to arbitrate; a nonzero vector is held until claimed.
      if (claim)                        interrupt_vector <= '0;
      else if (interrupt_vector == '0)  interrupt_vector <= win_vec;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed latency/claim scenarios plus randomized pulse/enable rounds,
// with presented vectors checked against a predicted claim order.
module tb_irq_controller;

  logic       CLOCK_50;
  logic       KEY0;
  logic [7:0] irq_src;
  logic [7:0] irq_enable;
  logic       interrupt_ack;
  logic [3:0] interrupt_vector;
  logic       irq_active;
  logic [7:0] pending;
  logic [7:0] overrun;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] exp_q[$];
  int         order_q[$];
  logic [7:0] pend_m;
  logic [7:0] ovr_m;

  irq_controller #(
    .NUM_SRC(8), .VEC_W(4), .EDGE_MASK(8'hFE), .SYNC_STAGES(2)
  ) dut (
    .CLOCK_50(CLOCK_50), .KEY0(KEY0), .irq_src(irq_src), .irq_enable(irq_enable),
    .interrupt_ack(interrupt_ack), .interrupt_vector(interrupt_vector),
    .irq_active(irq_active), .pending(pending), .overrun(overrun)
  );

  // clock / watchdog
  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic ack_pulse();
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
  endtask

  task automatic wait_vec(input string name);
    int n;
    n = 0;
    while (interrupt_vector == 4'd0 && n < 50) begin
      tick();
      n++;
    end
    chk(name, 32'(interrupt_vector != 4'd0), 32'd1);
  endtask

  function automatic int lowest(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return -1;
  endfunction

  // scoreboard monitor: every fresh presentation must match the next predicted vector
  initial begin
    logic [3:0] prev_vec;
    logic [3:0] e;
    prev_vec = 4'd0;
    forever begin
      @(negedge CLOCK_50);
      if (interrupt_vector != 4'd0 && prev_vec == 4'd0) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_vector: got %0d, required no presentation", interrupt_vector);
        end else begin
          e = exp_q.pop_front();
          if (interrupt_vector !== e) begin
            n_err++;
            $display("FAIL presented_vector: got %0d, required %0d", interrupt_vector, e);
          end
        end
      end
      prev_vec = interrupt_vector;
    end
  end

  // stimulus
  initial begin
    logic [7:0] en, p, p2, old, cand_m, seen;
    int         f;

    KEY0 = 1'b0;
    irq_src = 8'h00;
    irq_enable = 8'h00;
    interrupt_ack = 1'b0;
    ticks(3);
    chk("reset_vector", 32'(interrupt_vector), 0);
    chk("reset_active", 32'(irq_active), 0);
    chk("reset_pending", 32'(pending), 0);
    chk("reset_overrun", 32'(overrun), 0);
    KEY0 = 1'b1;
    ticks(2);

    // 1: edge src3, latency and single claim
    irq_enable = 8'hFF;
    exp_q.push_back(4'd4);
    irq_src[3] = 1'b1;
    ticks(2);
    chk("t1_pending_edge2", 32'(pending[3]), 0);
    tick();
    chk("t1_pending_edge3", 32'(pending[3]), 1);
    chk("t1_vector_edge3", 32'(interrupt_vector), 0);
    irq_src[3] = 1'b0;
    tick();
    chk("t1_vector_edge4", 32'(interrupt_vector), 4);
    chk("t1_active_edge4", 32'(irq_active), 1);
    ack_pulse();
    chk("t1_vector_claimed", 32'(interrupt_vector), 0);
    chk("t1_pending_claimed", 32'(pending[3]), 0);
    tick();
    chk("t1_active_cleared", 32'(irq_active), 0);

    // 2: simultaneous src1/src5, priority and gap cycle
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd6);
    irq_src = 8'h22;
    ticks(3);
    irq_src = 8'h00;
    wait_vec("t2_first_present");
    chk("t2_first_vector", 32'(interrupt_vector), 2);
    ack_pulse();
    chk("t2_gap_vector", 32'(interrupt_vector), 0);
    tick();
    chk("t2_second_vector", 32'(interrupt_vector), 6);
    ack_pulse();
    chk("t2_final_vector", 32'(interrupt_vector), 0);
    tick();
    chk("t2_active_cleared", 32'(irq_active), 0);
    chk("t2_pending_cleared", 32'(pending), 0);

    // 3: masked source latches pending, presents once enabled
    irq_enable = 8'hFB;
    irq_src[2] = 1'b1;
    ticks(3);
    irq_src[2] = 1'b0;
    ticks(3);
    chk("t3_masked_pending", 32'(pending[2]), 1);
    chk("t3_masked_vector", 32'(interrupt_vector), 0);
    exp_q.push_back(4'd3);
    irq_enable = 8'hFF;
    tick();
    chk("t3_enabled_vector", 32'(interrupt_vector), 3);
    ack_pulse();
    chk("t3_claimed_vector", 32'(interrupt_vector), 0);

    // 4: level src0 claimed while high stays quiet until it drops and re-rises
    exp_q.push_back(4'd1);
    irq_src[0] = 1'b1;
    wait_vec("t4_level_present");
    chk("t4_level_vector", 32'(interrupt_vector), 1);
    ack_pulse();
    seen = 8'h00;
    for (int i = 0; i < 10; i++) begin
      seen = seen | {4'h0, interrupt_vector} | pending;
      tick();
    end
    chk("t4_quiet_while_high", 32'(seen), 0);
    irq_src[0] = 1'b0;
    ticks(5);
    chk("t4_pending_low", 32'(pending[0]), 0);
    exp_q.push_back(4'd1);
    irq_src[0] = 1'b1;
    wait_vec("t4_rerise_present");
    chk("t4_rerise_vector", 32'(interrupt_vector), 1);
    ack_pulse();
    irq_src[0] = 1'b0;
    ticks(4);
    chk("t4_no_overrun", 32'(overrun), 0);

    // 5: second edge on src4 before claim sets overrun
    exp_q.push_back(4'd5);
    irq_src[4] = 1'b1; ticks(2);
    irq_src[4] = 1'b0; ticks(2);
    irq_src[4] = 1'b1; ticks(2);
    irq_src[4] = 1'b0; ticks(6);
    chk("t5_vector", 32'(interrupt_vector), 5);
    chk("t5_pending", 32'(pending[4]), 1);
    chk("t5_overrun", 32'(overrun[4]), 1);
    ack_pulse();
    chk("t5_pending_claimed", 32'(pending[4]), 0);
    chk("t5_overrun_claimed", 32'(overrun[4]), 0);
    chk("t5_vector_claimed", 32'(interrupt_vector), 0);

    // 6: ack held high gives exactly one claim; async reset mid-presentation
    exp_q.push_back(4'd7);
    exp_q.push_back(4'd8);
    irq_src = 8'hC0;
    ticks(3);
    irq_src = 8'h00;
    wait_vec("t6_present");
    chk("t6_first_vector", 32'(interrupt_vector), 7);
    interrupt_ack = 1'b1;
    tick();
    chk("t6_claim_vector", 32'(interrupt_vector), 0);
    tick();
    chk("t6_second_vector", 32'(interrupt_vector), 8);
    ticks(998);
    chk("t6_held_vector", 32'(interrupt_vector), 8);
    chk("t6_held_pending", 32'(pending), 32'h80);
    interrupt_ack = 1'b0;
    tick();
    chk("t6_after_release", 32'(interrupt_vector), 8);
    #3 KEY0 = 1'b0;
    #1;
    chk("t6_rst_vector", 32'(interrupt_vector), 0);
    chk("t6_rst_active", 32'(irq_active), 0);
    chk("t6_rst_pending", 32'(pending), 0);
    chk("t6_rst_overrun", 32'(overrun), 0);
    #2 KEY0 = 1'b1;
    ticks(3);
    chk("t6_post_reset_vector", 32'(interrupt_vector), 0);

    // randomized rounds: predicted claim order and final pending/overrun bits
    pend_m = 8'h00;
    ovr_m = 8'h00;
    for (int it = 0; it < 30; it++) begin
      en = 8'($urandom_range(0, 255));
      p  = 8'($urandom_range(0, 255)) & 8'hFE;
      p2 = p & 8'($urandom_range(0, 255));
      old = pend_m & en;
      ovr_m = ovr_m | (p & pend_m) | p2;
      pend_m = pend_m | p;
      cand_m = pend_m & en;
      order_q.delete();
      if (cand_m != 8'h00) begin
        f = (old != 8'h00) ? lowest(old) : lowest(p & en);
        order_q.push_back(f);
        cand_m[f] = 1'b0;
        while (cand_m != 8'h00) begin
          f = lowest(cand_m);
          order_q.push_back(f);
          cand_m[f] = 1'b0;
        end
      end
      foreach (order_q[k]) exp_q.push_back(4'(order_q[k] + 1));

      irq_enable = en;
      ticks(3);
      irq_src = p;  ticks(2);
      irq_src = 8'h00; ticks(2);
      if (p2 != 8'h00) begin
        irq_src = p2; ticks(2);
        irq_src = 8'h00; ticks(2);
      end
      ticks(4);

      foreach (order_q[k]) begin
        wait_vec("rand_present");
        ack_pulse();
        tick();
        pend_m[order_q[k]] = 1'b0;
        ovr_m[order_q[k]] = 1'b0;
      end
      ticks(2);
      chk("rand_pending", 32'(pending), 32'(pend_m));
      chk("rand_overrun", 32'(overrun), 32'(ovr_m));
      chk("rand_idle_vector", 32'(interrupt_vector), 0);
    end

    ticks(2);
    chk("exp_q_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
